z80_ram_sequencer: RTL and testbench
====================================

Z80_RAM_SEQUENCER -- requirements
Module: z80_ram_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_BITS, 20, host/RAM address width; MEM_SIZE_BITS, 15, log2 of implemented GPU RAM bytes; FIFO_DEPTH, 4, command queue entries (power of 2); RD_LATENCY, 2, RAM read latency in GPU_CLK cycles (1..4).
REQ-002 SHALL have ports, in this order:
- GPU_CLK  in  1  sole clock, 125 MHz.
- reset  in  1  asynchronous, active-low reset.
- host_wr_ena  in  1  write request level from Z80 bridge.
- host_rd_req  in  1  read request level from Z80 bridge.
- host_addr  in  ADDR_BITS  request address.
- host_wdata  in  8  write data.
- host_rdata  out  8  read data returned to bridge.
- host_rd_rdy  out  1  one-cycle pulse: host_rdata valid.
- ram_slot  in  1  high = RAM host port free this cycle.
- ram_addr  out  ADDR_BITS  RAM port address.
- ram_wdata  out  8  RAM write data.
- ram_wr_ena  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data, RD_LATENCY cycles after address.
- fifo_full  out  1  queue holds FIFO_DEPTH entries.
- ovf_err  out  1  sticky: request dropped (full or collision).

Function
REQ-003 SHALL register host_wr_ena/host_rd_req and treat only a 0->1 transition as one request; held levels (multi-cycle bridge strobes) SHALL NOT create further requests.
REQ-004 SHALL sample host_addr and host_wdata in the cycle the rising edge is detected and enqueue {op, addr, data}.
REQ-005 Simultaneous write and read edges: write SHALL be enqueued, read SHALL be dropped, ovf_err SHALL set.
REQ-006 Push while full SHALL be dropped and set ovf_err, unless a pop occurs the same cycle, in which case the push SHALL be accepted.
REQ-007 Issue FSM states: IDLE (queue empty), WAIT_SLOT (queue non-empty, ram_slot low), ISSUE (pop head in a cycle with ram_slot high); at most one command popped per cycle; IDLE->WAIT_SLOT on non-empty, WAIT_SLOT->ISSUE on ram_slot, ISSUE->IDLE/WAIT_SLOT by remaining occupancy.
REQ-008 Issued write: ram_addr/ram_wdata driven and ram_wr_ena high for exactly one cycle (the cycle after pop).
REQ-009 Issued read: ram_addr driven one cycle after pop; ram_rdata captured into host_rdata RD_LATENCY cycles later with host_rd_rdy high that cycle only.
REQ-010 Reads SHALL be pipelined: back-to-back reads on consecutive slots return in issue order, one host_rd_rdy each.
REQ-011 Commands SHALL complete in FIFO order; a read after a write to the same address SHALL return the new data.
REQ-012 Minimum latency read edge -> host_rd_rdy with ram_slot held high: RD_LATENCY + 3 cycles.
REQ-013 ram_wr_ena SHALL be low whenever no write is issued; ram_addr/ram_wdata hold last values otherwise.
REQ-014 ovf_err SHALL clear only on reset.

Reset
REQ-015 On reset low: queue empty, FSM IDLE, read pipeline flushed, edge registers cleared to 0; host_rdata=8'h00, host_rd_rdy=0, ram_addr=0, ram_wdata=0, ram_wr_ena=0, fifo_full=0, ovf_err=0.
REQ-016 Reset mid-operation SHALL discard queued and in-flight commands; no host_rd_rdy pulse for them after release.
REQ-017 A host strobe already high at reset release SHALL NOT be counted as a request.

Configuration
REQ-018 Macro RAM_SEQ_RANGE_CHECK_EN defined: commands with addr >= 2**MEM_SIZE_BITS SHALL still occupy a slot, writes SHALL NOT assert ram_wr_ena, reads SHALL return 8'hFF at normal latency.
REQ-019 Macro undefined: no range check; address bits above MEM_SIZE_BITS SHALL be forced to 0 on ram_addr (aliasing).

Verification
REQ-020 ram_slot=1, host_wr_ena high 2 cycles, addr 0x00123, data 0xA5 -> exactly one ram_wr_ena pulse, ram_addr 0x00123, ram_wdata 0xA5.
REQ-021 Write 0x5A to 0x00010, then read 0x00010, ram_slot=1 -> host_rd_rdy one cycle, host_rdata 0x5A, RD_LATENCY+3 cycles after read edge.
REQ-022 ram_slot=0, 5 write edges -> fifo_full=1 after 4, 5th dropped, ovf_err=1; ram_slot=1 -> exactly 4 writes in order.
REQ-023 Same-cycle rd and wr edges -> one write issued, no host_rd_rdy, ovf_err=1.
REQ-024 RAM_SEQ_RANGE_CHECK_EN, read 0x08000 -> host_rdata 0xFF; write 0x08000 -> no ram_wr_ena.
REQ-025 Reset low with 3 queued reads in flight -> all outputs at reset values, no host_rd_rdy after release.

Source files
------------

// File: rtl/z80_ram_sequencer.sv
// Z80 host -> GPU RAM sequencer: edge-detected requests, command FIFO, slot-gated issue, pipelined reads.
// Build option RAM_SEQ_RANGE_CHECK_EN: out-of-range writes are suppressed and out-of-range reads return 8'hFF.
//
// state     | meaning
// IDLE      | queue empty
// WAIT_SLOT | queue non-empty, waiting for ram_slot
// ISSUE     | head popped last cycle and now on the RAM port; pops again if slot and queue allow
module z80_ram_sequencer #(
   parameter int ADDR_BITS     = 20,
   parameter int MEM_SIZE_BITS = 15,
   parameter int FIFO_DEPTH    = 4,
   parameter int RD_LATENCY    = 2
) (
   input  logic                 GPU_CLK,
   input  logic                 reset,
   input  logic                 host_wr_ena,
   input  logic                 host_rd_req,
   input  logic [ADDR_BITS-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic [7:0]           host_rdata,
   output logic                 host_rd_rdy,
   input  logic                 ram_slot,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   output logic                 ram_wr_ena,
   input  logic [7:0]           ram_rdata,
   output logic                 fifo_full,
   output logic                 ovf_err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = ADDR_BITS + 9;
   localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_BITS-1:0] MEM_MASK = ADDR_BITS'((64'd1 << MEM_SIZE_BITS) - 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_SLOT, S_ISSUE} state_t;

   state_t               state_q, state_d;
   logic                 wr_prev_q, rd_prev_q, armed_q;
   logic [ENT_W-1:0]     fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr_q, rptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic [ADDR_BITS-1:0] ram_addr_q;
   logic [7:0]           ram_wdata_q;
   logic                 ram_wr_ena_q;
   logic [RD_LATENCY:0]  rdv_q, oor_q;
   logic [7:0]           host_rdata_q;
   logic                 host_rd_rdy_q;

   logic                 wr_edge, rd_edge, push, pop, full;
   logic [ENT_W-1:0]     push_ent, head;
   logic                 head_wr, head_oor;
   logic [ADDR_BITS-1:0] head_addr, issue_addr;
   logic [7:0]           head_data;

   // armed_q masks the first cycle after reset so a strobe held through release is not an edge
   assign wr_edge  = armed_q & host_wr_ena & ~wr_prev_q;
   assign rd_edge  = armed_q & host_rd_req & ~rd_prev_q;
   assign full     = (count_q == DEPTH_C);
   assign push_ent = {wr_edge, host_addr, host_wdata};
   assign head     = fifo_q[rptr_q];
   assign {head_wr, head_addr, head_data} = head;

`ifdef RAM_SEQ_RANGE_CHECK_EN
   assign head_oor   = (head_addr & ~MEM_MASK) != '0;
   assign issue_addr = head_addr;
`else
   assign head_oor   = 1'b0;
   assign issue_addr = head_addr & MEM_MASK;
`endif

   always_comb begin
      state_d = state_q;
      pop     = (state_q != S_IDLE) && ram_slot && (count_q != '0);
      push    = (wr_edge | rd_edge) & (~full | pop);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      ovf_d   = ovf_q | (wr_edge & rd_edge) | ((wr_edge | rd_edge) & full & ~pop);
      case (state_q)
         S_IDLE: begin
            if (count_d != '0) state_d = S_WAIT_SLOT;
         end
         default: begin
            if (pop)                 state_d = S_ISSUE;
            else if (count_d != '0)  state_d = S_WAIT_SLOT;
            else                     state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge GPU_CLK or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         wr_prev_q     <= 1'b0;
         rd_prev_q     <= 1'b0;
         armed_q       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_wr_ena_q  <= 1'b0;
         rdv_q         <= '0;
         oor_q         <= '0;
         host_rdata_q  <= 8'h00;
         host_rd_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_prev_q <= host_wr_ena;
         rd_prev_q <= host_rd_req;
         armed_q   <= 1'b1;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         if (push) begin
            fifo_q[wptr_q] <= push_ent;
            wptr_q         <= wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_q     <= rptr_q + PTR_W'(1);
            ram_addr_q <= issue_addr;
            if (head_wr) ram_wdata_q <= head_data;
         end
         ram_wr_ena_q  <= pop & head_wr & ~head_oor;
         // each stage tracks one issued read until its RAM data is due
         rdv_q         <= {rdv_q[RD_LATENCY-1:0], pop & ~head_wr};
         oor_q         <= {oor_q[RD_LATENCY-1:0], head_oor};
         host_rd_rdy_q <= rdv_q[RD_LATENCY];
         if (rdv_q[RD_LATENCY]) host_rdata_q <= oor_q[RD_LATENCY] ? 8'hFF : ram_rdata;
      end
   end

   assign host_rdata  = host_rdata_q;
   assign host_rd_rdy = host_rd_rdy_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_wr_ena  = ram_wr_ena_q;
   assign fifo_full   = full;
   assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_z80_ram_sequencer.sv
// Scoreboard bench for z80_ram_sequencer: directed stimulus pushes expectations, a negedge monitor pops and compares.
module tb_z80_ram_sequencer;

   localparam int AB = 20;
   localparam int L  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_wr_ena = 1'b0, host_rd_req = 1'b0;
   logic [AB-1:0] host_addr = '0;
   logic [7:0]    host_wdata = '0;
   logic [7:0]    host_rdata;
   logic          host_rd_rdy;
   logic          ram_slot = 1'b0;
   logic [AB-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_wr_ena;
   logic [7:0]    ram_rdata;
   logic          fifo_full, ovf_err;

   z80_ram_sequencer #(.ADDR_BITS(AB), .MEM_SIZE_BITS(15), .FIFO_DEPTH(4), .RD_LATENCY(L)) dut (
      .GPU_CLK(clk), .reset(rst_n), .host_wr_ena(host_wr_ena), .host_rd_req(host_rd_req),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .host_rd_rdy(host_rd_rdy), .ram_slot(ram_slot), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_wr_ena(ram_wr_ena), .ram_rdata(ram_rdata),
      .fifo_full(fifo_full), .ovf_err(ovf_err));

   always #4 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0;
   int wr_pulses = 0, rd_pulses = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [AB-1:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [7:0] data; int cyc; } rd_t;
   wr_t exp_wr[$];
   rd_t exp_rd[$];
   wr_t mw;
   rd_t mr;

   // RAM model: address seen in cycle A gives data in cycle A+L
   logic [7:0] mem [256];
   logic [7:0] rpipe [L];
   always @(posedge clk) begin
      if (ram_wr_ena) mem[ram_addr[7:0]] <= ram_wdata;
      rpipe[0] <= mem[ram_addr[7:0]];
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[L-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_wr_ena) begin
         wr_pulses++;
         if (exp_wr.size() == 0) chk("wr_unexpected", 32'(ram_wr_ena), 32'd0);
         else begin
            mw = exp_wr.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(mw.addr));
            chk("wr_data", 32'(ram_wdata), 32'(mw.data));
         end
      end
      if (host_rd_rdy) begin
         rd_pulses++;
         if (exp_rd.size() == 0) chk("rd_unexpected", 32'(host_rd_rdy), 32'd0);
         else begin
            mr = exp_rd.pop_front();
            chk("rd_data", 32'(host_rdata), 32'(mr.data));
            if (mr.cyc != 0) chk("rd_latency", cyc, mr.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AB-1:0] a, input logic [7:0] d, input int hold, input bit en);
      host_wr_ena = 1'b1; host_addr = a; host_wdata = d;
      if (en) exp_wr.push_back('{addr: a, data: d});
      tick(hold);
      host_wr_ena = 1'b0;
      tick(1);
   endtask

   task automatic rd(input logic [AB-1:0] a, input logic [7:0] d, input bit timed);
      host_rd_req = 1'b1; host_addr = a;
      exp_rd.push_back('{data: d, cyc: timed ? cyc + L + 3 : 0});
      tick(1);
      host_rd_req = 1'b0;
      tick(1);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_wr.size() + exp_rd.size()) != 0 && k < 200) begin
         tick(1);
         k++;
      end
      chk("drain_timeout", exp_wr.size() + exp_rd.size(), 0);
      tick(4);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdata"}, 32'(host_rdata), 32'h00);
      chk({tag, "_rdy"},   32'(host_rd_rdy), 32'd0);
      chk({tag, "_raddr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
      chk({tag, "_wena"},  32'(ram_wr_ena), 32'd0);
      chk({tag, "_full"},  32'(fifo_full), 32'd0);
      chk({tag, "_ovf"},   32'(ovf_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by 200us, required finish");
      $fatal(1);
   end

   int w0, r0;
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      tick(3);
      chk_reset("reset");
      rst_n = 1'b1;
      tick(2);
      ram_slot = 1'b1;

      // two-cycle write strobe gives exactly one RAM write
      w0 = wr_pulses;
      wr(20'h00123, 8'hA5, 2, 1'b1);
      drain();
      chk("one_wr_pulse", wr_pulses - w0, 1);

      // write then read same address at minimum latency
      host_wr_ena = 1'b1; host_addr = 20'h00010; host_wdata = 8'h5A;
      exp_wr.push_back('{addr: 20'h00010, data: 8'h5A});
      tick(1);
      host_wr_ena = 1'b0;
      rd(20'h00010, 8'h5A, 1'b1);
      drain();

      // three reads queued, then issued on consecutive slots
      for (int i = 0; i < 3; i++) wr(20'h00020 + 20'(i), 8'(8'h11 * (i + 1)), 1, 1'b1);
      drain();
      ram_slot = 1'b0;
      r0 = rd_pulses;
      for (int i = 0; i < 3; i++) rd(20'h00020 + 20'(i), 8'(8'h11 * (i + 1)), 1'b0);
      ram_slot = 1'b1;
      drain();
      chk("pipelined_rdy_count", rd_pulses - r0, 3);

      // overflow with slot blocked
      chk("ovf_before", 32'(ovf_err), 32'd0);
      ram_slot = 1'b0;
      w0 = wr_pulses;
      for (int i = 0; i < 5; i++) begin
         wr(20'h00040 + 20'(i), 8'hC0 + 8'(i), 1, i < 4);
         if (i == 3) begin
            chk("full_after_4", 32'(fifo_full), 32'd1);
            chk("ovf_after_4", 32'(ovf_err), 32'd0);
         end
      end
      chk("full_after_5", 32'(fifo_full), 32'd1);
      chk("ovf_after_5", 32'(ovf_err), 32'd1);
      ram_slot = 1'b1;
      drain();
      chk("full_drained", 32'(fifo_full), 32'd0);
      chk("four_writes", wr_pulses - w0, 4);

      // reset with reads in flight; write strobe held through release
      ram_slot = 1'b0;
      r0 = rd_pulses;
      w0 = wr_pulses;
      for (int i = 0; i < 3; i++) begin
         host_rd_req = 1'b1; host_addr = 20'h00020 + 20'(i);
         tick(1);
         host_rd_req = 1'b0;
         tick(1);
      end
      ram_slot = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      host_wr_ena = 1'b1; host_addr = 20'h00050; host_wdata = 8'hEE;
      chk_reset("midop_reset");
      tick(2);
      rst_n = 1'b1;
      tick(6);
      host_wr_ena = 1'b0;
      tick(8);
      chk("no_rdy_after_reset", rd_pulses - r0, 0);
      chk("no_wr_held_strobe", wr_pulses - w0, 0);
      chk("ovf_cleared", 32'(ovf_err), 32'd0);

      // simultaneous write and read edges
      r0 = rd_pulses;
      host_wr_ena = 1'b1; host_rd_req = 1'b1; host_addr = 20'h00030; host_wdata = 8'h77;
      exp_wr.push_back('{addr: 20'h00030, data: 8'h77});
      tick(1);
      host_wr_ena = 1'b0; host_rd_req = 1'b0;
      tick(1);
      drain();
      chk("collide_ovf", 32'(ovf_err), 32'd1);
      chk("collide_no_rdy", rd_pulses - r0, 0);

      // address 0x08000 is beyond the 32 KiB RAM
      w0 = wr_pulses;
`ifdef RAM_SEQ_RANGE_CHECK_EN
      wr(20'h08000, 8'h3C, 1, 1'b0);
      rd(20'h08000, 8'hFF, 1'b1);
      drain();
      chk("oor_no_write", wr_pulses - w0, 0);
`else
      exp_wr.push_back('{addr: 20'h00000, data: 8'h3C});
      wr(20'h08000, 8'h3C, 1, 1'b0);
      rd(20'h08000, 8'h3C, 1'b1);
      drain();
      chk("alias_write", wr_pulses - w0, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
